// File: rtl/cache_types_pkg.sv
// cache_types_pkg: shared line/beat widths, data types and adaptor FSM states.
package cache_types_pkg;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    typedef logic [LINE_W-1:0]  cacheline_t;
    typedef logic [BURST_W-1:0] burst_t;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} adaptor_state_e;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: turns one cache-line read/write into a BEATS-beat memory burst
// and returns a single-cycle completion to the cache.
module cacheline_adaptor #(
    parameter int LINE_W  = cache_types_pkg::LINE_W,
    parameter int BURST_W = cache_types_pkg::BURST_W,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);
    import cache_types_pkg::*;
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CW    = $clog2(BEATS);
    localparam int OFF   = $clog2(LINE_W / 8);
    adaptor_state_e    state, state_n;
    logic [CW-1:0]     beat;
    logic [LINE_W-1:0] wbuf;
    logic              last;
    assign last = beat == CW'(BEATS - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = (state == IDLE) ? (read_i ? READ : write_i ? WRITE : IDLE)
                : (state == DONE) ? IDLE
                : (resp_i && last) ? DONE : state;
    end
    always_comb begin
        read_o  = state == READ;
        write_o = state == WRITE;
        resp_o  = state == DONE;
    end
    // The write buffer shifts down one beat per accept, so the next beat is always at [2*BURST_W-1:BURST_W].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat      <= '0;
            wbuf      <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
        end else begin
            case (state)
                IDLE: if (read_i || write_i) begin
                    address_o <= (address_i >> OFF) << OFF;
                    beat      <= '0;
                    if (!read_i) begin
                        wbuf    <= line_i;
                        burst_o <= line_i[BURST_W-1:0];
                    end
                end
                READ: if (resp_i) begin
                    line_o[beat*BURST_W +: BURST_W] <= burst_i;
                    beat <= beat + 1'b1;
                end
                WRITE: if (resp_i) begin
                    wbuf    <= wbuf >> BURST_W;
                    burst_o <= wbuf[2*BURST_W-1:BURST_W];
                    beat    <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cacheline_adaptor.md
# cacheline_adaptor

- Initiator-side bridge between the L2/last-level cache and the burst physical-memory interface served by ParamMemory on `mem_itf`.
- Converts one cache-line read or write request into a 4-beat × 64-bit burst.
- Assembles read beats into a line and serialises write lines into beats.
- Returns a single-cycle completion to the cache.

## Interface
Parameters:
- `LINE_W`, 256: cache line width in bits.
- `BURST_W`, 64: memory beat width in bits.
- `ADDR_W`, 32: address width.
- `BEATS`: derived as `LINE_W/BURST_W` (4); not overridable.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1: system clock.
- `rst` in 1: async active-high reset.
- `line_i` in LINE_W: write line from cache.
- `line_o` out LINE_W: assembled read line.
- `address_i` in ADDR_W: cache request address.
- `read_i` in 1: cache line read request.
- `write_i` in 1: cache line write request.
- `resp_o` out 1: one-cycle completion pulse.
- `burst_i` in BURST_W: read beat from memory.
- `burst_o` out BURST_W: write beat to memory.
- `address_o` out ADDR_W: line-aligned burst address.
- `read_o` out 1: burst read request.
- `write_o` out 1: burst write request.
- `resp_i` in 1: memory beat strobe.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE:**
  - `read_i` → latch `{address_i[ADDR_W-1:5],5'b0}` into `address_o`, clear beat count, go to READ.
  - Else `write_i` → additionally latch `line_i` into the write buffer, go to WRITE.
  - `read_i` and `write_i` both high: read wins and the write is ignored.
- **READ:**
  - `read_o`=1.
  - Each cycle with `resp_i`=1: beat k of `burst_i` stores into `line_o[k*64 +: 64]`, k++.
  - After beat 3 is stored → DONE.
  - Gaps (`resp_i`=0) are tolerated; the count holds.
- **WRITE:**
  - `write_o`=1; `burst_o` = buffer[k*64 +: 64].
  - Each `resp_i`=1 advances k.
  - After beat 3 is accepted → DONE.
- **DONE:**
  - `resp_o`=1 for exactly one cycle; `read_o`/`write_o`=0; next state IDLE.
- **Beat order:** little-endian; beat 0 = line bits [63:0].
- **`line_o`:** holds its value from DONE until the next read's beat 0 overwrites it. Writes never modify it.
- **`address_o`:** holds its value after completion.
- **`resp_i` outside READ/WRITE:** ignored; no state change.
- **Cache obligation:** deassert the request in the cycle after `resp_o`. A request still high in IDLE starts a new transaction.
- **Reset (any time, including mid-burst):**
  - Immediate return to IDLE, beat count 0.
  - `read_o`, `write_o`, `resp_o` = 0.
  - `address_o`, `burst_o`, `line_o`, write buffer = 0.
  - A partial line is discarded and no `resp_o` is issued.

## Timing
- **Request acceptance:** the request is sampled at edge E0. `read_o`/`write_o` are high from cycle E0+1 and are registered (no combinational path from `read_i`/`write_i`).
- **Burst completion:** with the final `resp_i` at edge Ef, DONE occupies cycle Ef+1 and `resp_o` is high only in that cycle.
- **Latency:** with 4 back-to-back `resp_i` beats, request-to-`resp_o` = 1 + (memory first-beat latency) + 4 cycles.
- **Burst-request holding:** `read_o`/`write_o` stay asserted continuously from acceptance through the cycle of the final `resp_i`. They deassert on the following edge.
- **Write data:** `burst_o` is registered and valid before `resp_i` for its beat. It changes only on edges where `resp_i`=1 in WRITE.
- **Back-to-back requests:** a new request is accepted no earlier than the IDLE cycle following DONE (minimum 1 idle cycle between bursts).

## Structure
- Shared package `cache_types_pkg` holds:
  - `LINE_W`, `BURST_W`, `BEATS` constants;
  - `cacheline_t` and `burst_t` typedefs;
  - the `adaptor_state_e` enum (IDLE/READ/WRITE/DONE).
- Single module. A 2-bit beat counter and a 256-bit write-buffer shift are inline; no sub-module is warranted.

## Test plan
- **Read, consecutive beats:**
  - Stimulus: `read_i`=1, `address_i`=0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive `resp_i`.
  - Required: `address_o`=0x0000_1220; `line_o`={0x44..44,0x33..33,0x22..22,0x11..11}; `resp_o` pulses once, the cycle after the 4th beat.
- **Write, gapped acceptance:**
  - Stimulus: `write_i`=1, `line_i`={D3,D2,D1,D0}; `resp_i` pattern 1,0,1,0,0,1,1.
  - Required: `burst_o` presents D0,D1,D2,D3 in order, each held across the gaps; `write_o` stays high until the 4th accept; `resp_o` pulses once.
- **Simultaneous request:**
  - Stimulus: `read_i`=`write_i`=1.
  - Required: only `read_o` asserts; `write_o` remains 0 throughout.
- **Reset mid-burst:**
  - Stimulus: `rst` asserted asynchronously after 2 read beats.
  - Required: all outputs 0 immediately, no `resp_o`; a subsequent read completes normally with a fresh beat 0.
- **Spurious strobe in IDLE:**
  - Stimulus: `resp_i`=1 while in IDLE.
  - Required: no state change, `line_o` unchanged.
- **Back-to-back read then write:**
  - Required: the write starts one cycle after `resp_o`; the previous `line_o` is retained through the write.
